// File: rtl/isa_fetch_decode_pkg.sv
// Shared definitions for the ISA fetch/decode slice:
// opcodes, field layout, command encodings and FSM states.
package isa_fetch_decode_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 24;
    localparam int DEF_LEN_W  = 12;
    localparam int DEF_N_ENG  = 2;

    // Field layout is packed from the MSB: opcode, len, src, dst.
    localparam int OPC_W  = 4;
    localparam int OPC_HI = 63;
    localparam int OPC_LO = 60;
    localparam int LEN_HI = 59;
    localparam int LEN_LO = 48;
    localparam int SRC_HI = 47;
    localparam int SRC_LO = 24;
    localparam int DST_HI = 23;
    localparam int DST_LO = 0;

    localparam logic [OPC_W-1:0] OPC_NOP     = 4'd0;
    localparam logic [OPC_W-1:0] OPC_LOAD    = 4'd1;
    localparam logic [OPC_W-1:0] OPC_COMPUTE = 4'd2;
    localparam logic [OPC_W-1:0] OPC_STORE   = 4'd3;
    localparam logic [OPC_W-1:0] OPC_SYNC    = 4'd4;
    localparam logic [OPC_W-1:0] OPC_END     = 4'd15;

    typedef enum logic [1:0] {
        CMD_LOAD    = 2'd0,
        CMD_COMPUTE = 2'd1,
        CMD_STORE   = 2'd2
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_DECODE    = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_SYNC_WAIT = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

endpackage

// File: rtl/isa_fetch_decode_field.sv
// Combinational split of an instruction word into fields,
// plus engine-command and illegal-opcode classification.
import isa_fetch_decode_pkg::*;

module isa_field_decode #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic [DATA_W-1:0] i_instr,
    output logic [OPC_W-1:0]  o_opc,
    output logic [LEN_W-1:0]  o_len,
    output logic [ADDR_W-1:0] o_src,
    output logic [ADDR_W-1:0] o_dst,
    output logic              o_is_cmd,
    output logic              o_illegal,
    output cmd_op_e           o_cmd_op
);

    localparam int OPC_LSB = DATA_W - OPC_W;
    localparam int LEN_LSB = OPC_LSB - LEN_W;
    localparam int SRC_LSB = LEN_LSB - ADDR_W;

    assign o_opc = i_instr[DATA_W-1:OPC_LSB];
    assign o_len = i_instr[OPC_LSB-1:LEN_LSB];
    assign o_src = i_instr[LEN_LSB-1:SRC_LSB];
    assign o_dst = i_instr[ADDR_W-1:0];

    always_comb begin
        o_is_cmd  = 1'b0;
        o_illegal = 1'b0;
        o_cmd_op  = CMD_LOAD;
        unique case (o_opc)
            OPC_LOAD: begin
                o_is_cmd = 1'b1;
                o_cmd_op = CMD_LOAD;
            end
            OPC_COMPUTE: begin
                o_is_cmd = 1'b1;
                o_cmd_op = CMD_COMPUTE;
            end
            OPC_STORE: begin
                o_is_cmd = 1'b1;
                o_cmd_op = CMD_STORE;
            end
            OPC_NOP, OPC_SYNC, OPC_END: begin
                o_is_cmd = 1'b0;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/isa_fetch_decode.sv
// Pops instructions from the ISA FIFO, decodes them and issues
// engine commands; SYNC and END are handled locally.
import isa_fetch_decode_pkg::*;

module isa_fetch_decode #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int N_ENG  = DEF_N_ENG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] cmd_src,
    output logic [ADDR_W-1:0] cmd_dst,
    input  logic [N_ENG-1:0]  eng_busy,
    output logic              running,
    output logic              err_illegal,
    output logic [15:0]       instr_cnt
);

    state_e              r_state;
    logic [DATA_W-1:0]   r_instr;
    logic                r_cmd_valid;
    cmd_op_e             r_cmd_op;
    logic [LEN_W-1:0]    r_cmd_len;
    logic [ADDR_W-1:0]   r_cmd_src;
    logic [ADDR_W-1:0]   r_cmd_dst;
    logic                r_err;
    logic [15:0]         r_cnt;

    logic [OPC_W-1:0]    w_opc;
    logic [LEN_W-1:0]    w_len;
    logic [ADDR_W-1:0]   w_src;
    logic [ADDR_W-1:0]   w_dst;
    logic                w_is_cmd;
    logic                w_illegal;
    cmd_op_e             w_cmd_op;

    isa_field_decode #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_field (
        .i_instr   (r_instr),
        .o_opc     (w_opc),
        .o_len     (w_len),
        .o_src     (w_src),
        .o_dst     (w_dst),
        .o_is_cmd  (w_is_cmd),
        .o_illegal (w_illegal),
        .o_cmd_op  (w_cmd_op)
    );

    // The pop must see the live empty flag, so it is decoded from state.
    assign fifo_rd_en  = (r_state == ST_FETCH) && !fifo_empty;
    assign running     = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign cmd_valid   = r_cmd_valid;
    assign cmd_op      = r_cmd_op;
    assign cmd_len     = r_cmd_len;
    assign cmd_src     = r_cmd_src;
    assign cmd_dst     = r_cmd_dst;
    assign err_illegal = r_err;
    assign instr_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_instr     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= CMD_LOAD;
            r_cmd_len   <= '0;
            r_cmd_src   <= '0;
            r_cmd_dst   <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_instr <= fifo_dout;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    unique case (1'b1)
                        w_is_cmd: begin
                            r_cmd_op    <= w_cmd_op;
                            r_cmd_len   <= w_len;
                            r_cmd_src   <= w_src;
                            r_cmd_dst   <= w_dst;
                            r_cmd_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                        w_illegal: begin
                            r_err   <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                        (w_opc == OPC_SYNC): begin
                            r_state <= ST_SYNC_WAIT;
                        end
                        (w_opc == OPC_END): begin
                            r_cnt   <= r_cnt + 16'd1;
                            r_state <= ST_HALT;
                        end
                        default: begin
                            r_cnt   <= r_cnt + 16'd1;
                            r_state <= ST_FETCH;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= r_cnt + 16'd1;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_SYNC_WAIT: begin
                    if (eng_busy == '0) begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    // Resuming keeps the retired count from before END.
                    if (start) r_state <= ST_FETCH;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
